// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and FSM state type for the radix-16 Booth multiplier.
package mul_pkg;
  localparam int WIDTH = 32;
  localparam int N_STEPS = WIDTH / 4;
  localparam int CNT_W = $clog2(N_STEPS);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPT, S_DONE} mul_state_e;
endpackage

// File: rtl/mul_step_counter.sv
// mul_step_counter: shift-cycle counter with clear, enable and terminal-count flag.
module mul_step_counter #(
  parameter int N = mul_pkg::N_STEPS,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign last_o = cnt_q == CW'(N - 1);
  // Wrap explicitly at the terminal count so non-power-of-two step counts work.
  assign cnt_d = (clr_i | (en_i & last_o)) ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  assign cnt_o = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: handshake and sequencing controller for the radix-16 Booth multiplier datapath.
module mul_seq_ctrl import mul_pkg::*; #(
  parameter int WIDTH = mul_pkg::WIDTH,
  localparam int N_STEPS = WIDTH / 4,
  localparam int CNT_W = $clog2(N_STEPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             abort_i,
  output logic             opnd_we_o,
  output logic             load_o,
  output logic             capture_o,
  output logic [CNT_W-1:0] step_cnt_o,
  output logic             last_step_o,
  output logic             busy_o
);
  if (!(WIDTH % 4 == 0 && WIDTH >= 8)) begin : g_width_chk
    $error("mul_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end
  mul_state_e state_q, state_d;
  logic idle, run, capt, done, accept, last;
  assign idle = state_q == S_IDLE;
  assign run = state_q == S_RUN;
  assign capt = state_q == S_CAPT;
  assign done = state_q == S_DONE;
  assign in_ready_o = ~abort_i & (idle | (done & out_ready_i));
  assign accept = in_valid_i & in_ready_o;
  assign opnd_we_o = accept;
  // Accepting straight out of DONE gives back-to-back operation with no bubble.
  assign state_d = abort_i ? S_IDLE :
                   idle    ? (accept ? S_RUN : S_IDLE) :
                   run     ? (last ? S_CAPT : S_RUN) :
                   capt    ? S_DONE :
                   out_ready_i ? (accept ? S_RUN : S_IDLE) : S_DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  mul_step_counter #(.N(N_STEPS), .CW(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (~run | abort_i),
    .en_i   (run),
    .cnt_o  (step_cnt_o),
    .last_o (last)
  );
  assign load_o = ~run;
  assign capture_o = capt;
  assign out_valid_o = done;
  assign busy_o = run | capt;
  assign last_step_o = run & last;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed scoreboard bench for the Booth multiplier sequencing controller.
module tb_mul_seq_ctrl;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 0, abort = 0;
  logic in_ready, out_valid, opnd_we, load, capture, last_step, busy;
  logic [2:0] step_cnt;
  int cyc = 0, n_cmp = 0, n_err = 0;
  int sb[$];
  logic ov_prev = 0;

  mul_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .abort_i     (abort),
    .opnd_we_o   (opnd_we),
    .load_o      (load),
    .capture_o   (capture),
    .step_cnt_o  (step_cnt),
    .last_step_o (last_step),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Each new result must first present out_valid in the cycle pushed by the stimulus.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && !ov_prev) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
      else chk("out_valid_cycle", cyc, sb.pop_front());
    end
    ov_prev = out_valid;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // Issue one operand pair now (cycle 0) and walk it through RUN and CAPT to cycle 9.
  task automatic op_run();
    in_valid = 1;
    #1;
    chk("opnd_we_accept", opnd_we, 1);
    sb.push_back(cyc + 10);
    for (int k = 1; k <= 9; k++) begin
      tick();
      in_valid = 0;
      #1;
      if (k <= 8) begin
        chk("run_load", load, 0);
        chk("run_step_cnt", step_cnt, k - 1);
        chk("run_last_step", last_step, k == 8 ? 1 : 0);
        chk("run_capture", capture, 0);
        chk("run_busy", busy, 1);
      end else begin
        chk("capt_capture", capture, 1);
        chk("capt_load", load, 1);
        chk("capt_busy", busy, 1);
        chk("capt_out_valid", out_valid, 0);
      end
    end
  endtask

  initial begin
    tick();
    #1;
    chk("rst_load", load, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_capture", capture, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_last_step", last_step, 0);
    chk("rst_opnd_we", opnd_we, 0);
    tick();
    rst_n = 1;
    // Single operation with the consumer ready.
    tick();
    out_ready = 1;
    op_run();
    tick();
    #1;
    chk("done_load", load, 1);
    chk("done_busy", busy, 0);
    tick();
    #1;
    chk("idle_after_done_ov", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    // Backpressure: result held for 5 cycles while in_valid is ignored.
    tick();
    out_ready = 0;
    op_run();
    for (int k = 0; k < 5; k++) begin
      tick();
      in_valid = 1;
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_load", load, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_opnd_we", opnd_we, 0);
    end
    tick();
    in_valid = 0;
    out_ready = 1;
    #1;
    chk("bp_release_ov", out_valid, 1);
    tick();
    out_ready = 0;
    #1;
    chk("bp_idle_ov", out_valid, 0);
    chk("bp_idle_in_ready", in_ready, 1);
    // Back-to-back with in_valid and out_ready held high.
    tick();
    in_valid = 1;
    out_ready = 1;
    for (int k = 0; k < 31; k++) begin
      if (k > 0) tick();
      if (k == 30) in_valid = 0;
      #1;
      chk("b2b_opnd_we", opnd_we, (k % 10 == 0 && k < 30) ? 1 : 0);
      if (k % 10 == 0 && k < 30) sb.push_back(cyc + 10);
    end
    tick();
    #1;
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_ov", out_valid, 0);
    // Abort in RUN at step 3.
    tick();
    in_valid = 1;
    #1;
    chk("ab_run_accept", opnd_we, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      in_valid = 0;
      if (k == 4) abort = 1;
    end
    #1;
    chk("ab_run_step3", step_cnt, 3);
    chk("ab_run_in_ready", in_ready, 0);
    tick();
    abort = 0;
    #1;
    chk("ab_run_load", load, 1);
    chk("ab_run_step0", step_cnt, 0);
    chk("ab_run_busy", busy, 0);
    chk("ab_run_in_ready_after", in_ready, 1);
    for (int k = 0; k < 12; k++) begin
      tick();
      #1;
      chk("ab_run_no_capture", capture, 0);
    end
    op_run();
    tick();
    tick();
    // Abort in DONE together with in_valid and out_ready.
    out_ready = 0;
    op_run();
    tick();
    #1;
    chk("ab_done_ov", out_valid, 1);
    tick();
    abort = 1;
    in_valid = 1;
    out_ready = 1;
    #1;
    chk("ab_done_opnd_we", opnd_we, 0);
    chk("ab_done_in_ready", in_ready, 0);
    tick();
    abort = 0;
    in_valid = 0;
    #1;
    chk("ab_done_ov_drop", out_valid, 0);
    chk("ab_done_busy", busy, 0);
    chk("ab_done_load", load, 1);
    chk("ab_done_in_ready_after", in_ready, 1);
    // Asynchronous reset mid-RUN.
    tick();
    in_valid = 1;
    #1;
    chk("rst_run_accept", opnd_we, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      in_valid = 0;
    end
    #1;
    chk("rst_run_busy_pre", busy, 1);
    #1;
    rst_n = 0;
    #1;
    chk("rst_run_load", load, 1);
    chk("rst_run_busy", busy, 0);
    chk("rst_run_step_cnt", step_cnt, 0);
    chk("rst_run_out_valid", out_valid, 0);
    tick();
    rst_n = 1;
    #1;
    chk("rst_run_in_ready", in_ready, 1);
    tick();
    op_run();
    tick();
    tick();
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
